// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter: grants up to two register-file write ports per cycle
// to N requesters in round-robin order, with no same-register pair and with $zero writes absorbed.
module regfile_write_arbiter #(
   parameter int N     = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req_valid,
   input  logic [5*N-1:0]    req_reg,
   input  logic [32*N-1:0]   req_data,
   output logic [N-1:0]      req_ready,
   output logic [4:0]        write_reg1,
   output logic [31:0]       write_data1,
   output logic              reg_write1,
   output logic [4:0]        write_reg2,
   output logic [31:0]       write_data2,
   output logic              reg_write2,
   output logic [CNT_W-1:0]  defer_count
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam int DEF_W = $clog2(N + 1);

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             a_found, b_found;
   logic [PTR_W-1:0] a_idx, b_idx;
   logic [4:0]       a_reg, b_reg;
   logic [31:0]      a_data, b_data;
   logic [DEF_W-1:0] defer_n;

   logic [4:0]       write_reg1_q, write_reg1_d, write_reg2_q, write_reg2_d;
   logic [31:0]      write_data1_q, write_data1_d, write_data2_q, write_data2_d;
   logic             reg_write1_q, reg_write1_d, reg_write2_q, reg_write2_d;
   logic [CNT_W-1:0] defer_count_q, defer_count_d;
   logic [CNT_W:0]   cnt_sum;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      return (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
   endfunction

   // Scan from rr_ptr: $zero requests are always accepted; A is the first real write,
   // B the next one to a different register. Same-register requests seen before B are deferred.
   always_comb begin : select
      int idx;
      logic [PTR_W-1:0] sel;
      logic [4:0] r;
      idx       = 0;
      sel       = '0;
      r         = '0;
      req_ready = '0;
      a_found   = 1'b0;
      b_found   = 1'b0;
      a_idx     = '0;
      b_idx     = '0;
      a_reg     = '0;
      b_reg     = '0;
      a_data    = '0;
      b_data    = '0;
      defer_n   = '0;
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            r   = req_reg[5*sel +: 5];
            if (req_valid[sel]) begin
               if (r == 5'd0) begin
                  req_ready[sel] = 1'b1;
               end else if (!a_found) begin
                  a_found        = 1'b1;
                  a_idx          = sel;
                  a_reg          = r;
                  a_data         = req_data[32*sel +: 32];
                  req_ready[sel] = 1'b1;
               end else if (!b_found) begin
                  if (r == a_reg) begin
                     defer_n = defer_n + DEF_W'(1);
                  end else begin
                     b_found        = 1'b1;
                     b_idx          = sel;
                     b_reg          = r;
                     b_data         = req_data[32*sel +: 32];
                     req_ready[sel] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin : next_state
      rr_ptr_d = rr_ptr_q;
      if (b_found)      rr_ptr_d = wrap_inc(b_idx);
      else if (a_found) rr_ptr_d = wrap_inc(a_idx);

      reg_write1_d  = a_found;
      write_reg1_d  = a_found ? a_reg  : write_reg1_q;
      write_data1_d = a_found ? a_data : write_data1_q;
      reg_write2_d  = b_found;
      write_reg2_d  = b_found ? b_reg  : write_reg2_q;
      write_data2_d = b_found ? b_data : write_data2_q;

      cnt_sum       = {1'b0, defer_count_q} + (CNT_W+1)'(defer_n);
      defer_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q      <= '0;
         reg_write1_q  <= 1'b0;
         write_reg1_q  <= '0;
         write_data1_q <= '0;
         reg_write2_q  <= 1'b0;
         write_reg2_q  <= '0;
         write_data2_q <= '0;
         defer_count_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         reg_write1_q  <= reg_write1_d;
         write_reg1_q  <= write_reg1_d;
         write_data1_q <= write_data1_d;
         reg_write2_q  <= reg_write2_d;
         write_reg2_q  <= write_reg2_d;
         write_data2_q <= write_data2_d;
         defer_count_q <= defer_count_d;
      end
   end

   assign write_reg1  = write_reg1_q;
   assign write_data1 = write_data1_q;
   assign reg_write1  = reg_write1_q;
   assign write_reg2  = write_reg2_q;
   assign write_data2 = write_data2_q;
   assign reg_write2  = reg_write2_q;
   assign defer_count = defer_count_q;

endmodule
